// File: rtl/mcu_subsys_boot_loader_pkg.sv
// Shared types and constants for the MCU subsystem boot loader.
// State encoding is fixed so the values stay compatible with older debug tooling.
package mcu_subsys_pkg;

  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    COLLECT = 3'd2,
    WRITE   = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } boot_state_t;

  localparam logic [3:0] MEM_WSTRB_WORD = 4'hF;
  localparam logic [3:0] MEM_WSTRB_NONE = 4'h0;

endpackage

// File: rtl/mcu_subsys_boot_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs it into 32-bit words,
// writes them to SRAM over mem_valid/mem_ready and then releases the CPU reset.
module mcu_subsys_boot_loader
  import mcu_subsys_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned ADDR_SHIFT     = 2,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n,
  output logic [15:0] words_written
);

  boot_state_t state;
  boot_state_t state_next;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] timer;
  logic        byte_fire;
  logic        timer_expired;
  logic [15:0] hdr_count;
  logic [31:0] word_addr;

  assign byte_fire     = in_valid && in_ready;
  assign timer_expired = (timer == 32'(TIMEOUT_CYCLES - 1));
  assign hdr_count     = {in_data, count[7:0]};
  assign word_addr     = BASE_ADDR + ({16'h0000, word_idx} << ADDR_SHIFT);

  always_comb begin
    state_next = state;
    unique case (state)
      HDR0: if (byte_fire) state_next = HDR1;
      HDR1: begin
        if (byte_fire) begin
          if (hdr_count == 16'd0)
            state_next = DONE;
          else if ({16'h0000, hdr_count} > 32'(MAX_WORDS))
            state_next = ERROR;
          else
            state_next = COLLECT;
        end
      end
      COLLECT: if (byte_fire && byte_idx == 2'd3) state_next = WRITE;
      WRITE: begin
        if (mem_ready)
          state_next = GAP;
        else if (timer_expired)
          state_next = ERROR;
      end
      GAP:     state_next = (word_idx == count) ? DONE : COLLECT;
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = ERROR;
    endcase
  end

  // Handshake and status outputs are registered from the next state so they
  // line up with the state they describe, with no combinational path to ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HDR0;
      in_ready      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_rst_n     <= 1'b0;
      count         <= 16'd0;
      word_idx      <= 16'd0;
      byte_idx      <= 2'd0;
      timer         <= 32'd0;
      mem_valid     <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_wstrb     <= MEM_WSTRB_NONE;
      words_written <= 16'd0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == HDR0) || (state_next == HDR1) || (state_next == COLLECT);
      done      <= (state_next == DONE);
      error     <= (state_next == ERROR);
      cpu_rst_n <= (state_next == DONE);

      unique case (state)
        HDR0: if (byte_fire) count[7:0] <= in_data;
        HDR1: begin
          if (byte_fire) begin
            count[15:8] <= in_data;
            word_idx    <= 16'd0;
            byte_idx    <= 2'd0;
          end
        end
        COLLECT: begin
          if (byte_fire) begin
            unique case (byte_idx)
              2'd0: mem_wdata[7:0]   <= in_data;
              2'd1: mem_wdata[15:8]  <= in_data;
              2'd2: mem_wdata[23:16] <= in_data;
              2'd3: mem_wdata[31:24] <= in_data;
              default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_valid <= 1'b1;
              mem_addr  <= word_addr;
              mem_wstrb <= MEM_WSTRB_WORD;
              timer     <= 32'd0;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_valid     <= 1'b0;
            mem_wstrb     <= MEM_WSTRB_NONE;
            words_written <= words_written + 16'd1;
            word_idx      <= word_idx + 16'd1;
          end else if (timer_expired) begin
            mem_valid <= 1'b0;
            mem_wstrb <= MEM_WSTRB_NONE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_subsys_boot_loader.sv
// Randomized bench for the boot loader: images are modelled as expected word
// lists and compared against the writes seen on the memory port.
module tb_mcu_subsys_boot_loader;

  localparam logic [31:0] BASE = 32'h2000_0100;
  localparam int TMO  = 16;
  localparam int MAXW = 256;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        error;
  logic        cpu_rst_n;
  logic [15:0] words_written;

  mcu_subsys_boot_loader #(
    .BASE_ADDR     (BASE),
    .ADDR_SHIFT    (2),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .done         (done),
    .error        (error),
    .cpu_rst_n    (cpu_rst_n),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  int          resp_delay = 1;
  bit          never_ready = 1'b0;
  int          valid_len = 0;
  int          last_valid_len = 0;
  int          writes_issued = 0;
  int          completions = 0;
  int          stable_err = 0;
  int          gap_err = 0;
  bit          prev_fire = 1'b0;
  bit          last_valid = 1'b0;
  logic [31:0] held_addr;
  logic [31:0] held_data;
  logic [3:0]  held_strb;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  // Registered responder plus write monitor. Ready lingers one cycle after a
  // completion, like a real registered slave, so the GAP cycle sees it.
  always @(negedge clk) begin
    bit fire;
    if (!rst_n) begin
      mem_ready     = 1'b0;
      valid_len     = 0;
      prev_fire     = 1'b0;
      last_valid    = 1'b0;
      writes_issued = 0;
      completions   = 0;
      stable_err    = 0;
      gap_err       = 0;
    end else begin
      if (mem_valid) begin
        if (prev_fire) gap_err++;
        if (!last_valid) begin
          writes_issued++;
          held_addr = mem_addr;
          held_data = mem_wdata;
          held_strb = mem_wstrb;
        end else if (mem_addr !== held_addr || mem_wdata !== held_data || mem_wstrb !== held_strb) begin
          stable_err++;
        end
        mem_ready = !never_ready && (valid_len >= resp_delay);
        valid_len++;
      end else begin
        mem_ready = mem_ready && last_valid;
        if (last_valid) last_valid_len = valid_len;
        valid_len = 0;
      end
      fire = mem_valid && mem_ready;
      if (fire) begin
        completions++;
        if (exp_addr_q.size() == 0) begin
          check_output("wr_extra", 32'd1, 32'd0);
        end else begin
          check_output("wr_addr", mem_addr, exp_addr_q.pop_front());
          check_output("wr_data", mem_wdata, exp_data_q.pop_front());
          check_output("wr_strb", {28'd0, mem_wstrb}, 32'hF);
        end
      end
      prev_fire  = fire;
      last_valid = mem_valid;
    end
  end

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check_output({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    check_output({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_output({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    check_output({tag, "_done"}, {31'd0, done}, 32'd0);
    check_output({tag, "_error"}, {31'd0, error}, 32'd0);
    check_output({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check_output({tag, "_words"}, {16'd0, words_written}, 32'd0);
  endtask

  // Reset is asserted between clock edges and checked before the next edge.
  task automatic apply_reset(input string tag);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    else check_output("byte_accept", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic apply_stimulus(input logic [15:0] cnt, input int max_gap, input bit fixed, input int npay);
    logic [7:0] b[4];
    send_byte(cnt[7:0], max_gap);
    send_byte(cnt[15:8], max_gap);
    for (int w = 0; w < npay; w++) begin
      for (int k = 0; k < 4; k++) begin
        b[k] = fixed ? 8'(((w * 4 + k) % 15 + 1) * 17) : 8'($urandom);
        send_byte(b[k], max_gap);
      end
    end
  endtask

  task automatic build_expected(input int nwords, input bit fixed, input int seed_unused);
    for (int w = 0; w < nwords; w++) exp_addr_q.push_back(BASE + 32'(w * 4));
  endtask

  // Runs one whole image from HDR0 to DONE/ERROR and checks the final outcome.
  task automatic run_image(input logic [15:0] cnt, input int max_gap, input int delay,
                           input bit never, input bit fixed);
    logic [7:0] pay[$];
    int  nwords;
    int  waited;
    bit  exp_err;
    int  exp_words;
    int  exp_issued;
    resp_delay  = delay;
    never_ready = never;
    nwords      = (cnt == 0 || int'(cnt) > MAXW) ? 0 : int'(cnt);
    for (int i = 0; i < nwords * 4; i++)
      pay.push_back(fixed ? 8'(((i % 15) + 1) * 17) : 8'($urandom));
    for (int w = 0; w < nwords; w++) begin
      exp_addr_q.push_back(BASE + 32'(w) * 32'd4);
      exp_data_q.push_back({pay[w*4+3], pay[w*4+2], pay[w*4+1], pay[w*4]});
    end
    send_byte(cnt[7:0], max_gap);
    send_byte(cnt[15:8], max_gap);
    foreach (pay[i]) send_byte(pay[i], max_gap);
    waited = 0;
    while (!(done || error) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_output("finish_seen", {31'd0, done || error}, 32'd1);
    if (cnt == 0) check_output("zero_latency", {31'd0, waited <= 2}, 32'd1);
    @(negedge clk);
    exp_err    = never || (int'(cnt) > MAXW);
    exp_words  = exp_err ? 0 : nwords;
    exp_issued = never ? 1 : nwords;
    check_output("done", {31'd0, done}, {31'd0, !exp_err});
    check_output("error", {31'd0, error}, {31'd0, exp_err});
    check_output("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, !exp_err});
    check_output("in_ready_end", {31'd0, in_ready}, 32'd0);
    check_output("mem_valid_end", {31'd0, mem_valid}, 32'd0);
    check_output("words_written", {16'd0, words_written}, 32'(exp_words));
    check_output("completions", 32'(completions), 32'(exp_words));
    check_output("writes_issued", 32'(writes_issued), 32'(exp_issued));
    check_output("addr_stable", 32'(stable_err), 32'd0);
    check_output("gap_cycle", 32'(gap_err), 32'd0);
    check_output("exp_left", 32'(exp_addr_q.size()), never ? 32'd1 : 32'd0);
    if (never) check_output("timeout_len", 32'(last_valid_len), 32'(TMO));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] two-word image with input gaps");
    run_image(16'd2, 3, 1, 1'b0, 1'b1);

    $display("[TB] empty image");
    apply_reset("rst_a");
    run_image(16'd0, 0, 1, 1'b0, 1'b0);

    $display("[TB] oversize header");
    apply_reset("rst_b");
    run_image(16'd257, 1, 1, 1'b0, 1'b0);

    $display("[TB] slow responder");
    apply_reset("rst_c");
    run_image(16'd3, 1, 5, 1'b0, 1'b0);

    $display("[TB] bus timeout");
    apply_reset("rst_d");
    run_image(16'd1, 0, 1, 1'b1, 1'b0);

    $display("[TB] reset mid-image");
    apply_reset("rst_e");
    resp_delay  = 1;
    never_ready = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    apply_reset("mid");
    run_image(16'd1, 2, 1, 1'b0, 1'b0);

    $display("[TB] maximum image");
    apply_reset("rst_f");
    run_image(16'd256, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      apply_reset("rst_r");
      run_image(16'($urandom_range(8, 1)), int'($urandom_range(3, 0)),
                int'($urandom_range(5, 0)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_subsys_boot_loader.md
Name: mcu_subsys_boot_loader

Overview:
- Bus initiator that fills MCU SRAM from a byte stream (UART/SPI flash front-end) before the CPU starts.
- Parses a 2-byte length header, packs payload bytes little-endian into 32-bit words, and issues full-word writes on the mem_valid/mem_ready interface.
- Holds the CPU in reset until the image is loaded, then releases it.
- Sits between the boot byte source and the SRAM arbiter, on the same port the CPU later uses.

Parameters:
- BASE_ADDR, 32'h0000_0000, mem_addr of the first word.
- ADDR_SHIFT, 2, left shift applied to the word index to form the address offset.
- MAX_WORDS, 256, largest legal header word count.
- TIMEOUT_CYCLES, 1024, cycles mem_valid may stay high without mem_ready.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  byte source has data
- in_ready  out  1  loader accepts byte this cycle
- in_data  in  8  byte
- mem_valid  out  1  write request
- mem_ready  in  1  responder acknowledge
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables
- done  out  1  image loaded
- error  out  1  bad header or bus timeout
- cpu_rst_n  out  1  CPU reset, active-low
- words_written  out  16  completed word writes

Behaviour:
- Reset values: in_ready=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, error=0, cpu_rst_n=0, words_written=0. State goes to HDR0.
- Reset asserted mid-operation aborts immediately. Nothing is resumed; the next byte is treated as HDR0.
- Byte handshake: a byte transfers on a posedge where in_valid&&in_ready. in_ready is a registered output, 1 only in HDR0, HDR1 and COLLECT.
- HDR0: the accepted byte goes to count[7:0], then go to HDR1.
- HDR1: the accepted byte goes to count[15:8]. Then:
  - count==0 -> DONE.
  - count>MAX_WORDS -> ERROR.
  - otherwise -> COLLECT, with byte index 0 and word index 0.
- COLLECT: byte k (0..3) goes to wdata[8k+7:8k]. On the 4th byte, in the same edge:
  - mem_valid<=1
  - mem_addr<=BASE_ADDR+(word_idx<<ADDR_SHIFT), computed 32-bit with wrap
  - mem_wstrb<=4'hF
  - go to WRITE
- WRITE:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable.
  - The transfer completes on the first posedge with mem_valid&&mem_ready. At that edge: mem_valid<=0, mem_wstrb<=0, words_written++, word_idx++, go to GAP.
  - The timeout counter clears on entry and increments each WRITE cycle. When it reaches TIMEOUT_CYCLES-1 without mem_ready: mem_valid<=0, go to ERROR.
- GAP: exactly one cycle with mem_valid=0. The responder's registered mem_ready may still be 1 here and is ignored. Next state is DONE if word_idx==count, else COLLECT.
- mem_ready is ignored whenever mem_valid=0.
- mem_valid never rises in the cycle immediately after a completion.
- DONE: done=1, cpu_rst_n=1, in_ready=0. Sticky until reset.
- ERROR: error=1, cpu_rst_n=0, in_ready=0, mem_valid=0. Sticky until reset.
- done and error are never both 1.
- Throughput with a 1-cycle registered responder: 4th byte accepted at edge E0, mem_valid high after E0, mem_ready high after E1, completion at E2, GAP, in_ready high after E3.
- Stalls on in_valid are arbitrary. Partial word state is held indefinitely.

Decomposition:
- Package mcu_subsys_pkg holds:
  - boot_state_t enum {HDR0, HDR1, COLLECT, WRITE, GAP, DONE, ERROR}
  - MEM_WSTRB_WORD=4'hF
  - MEM_WSTRB_NONE=4'h0
- No sub-module is needed; the byte packer is 2-bit index logic inline.

Test Plan:
- Header 02 00, payload 11 22 33 44 55 66 77 88 with gaps in in_valid, registered 1-cycle responder -> writes (BASE+0, 0x44332211, F) and (BASE+4, 0x88776655, F). mem_valid=0 for ≥1 cycle between writes. words_written=2, done=1, cpu_rst_n=1.
- Header 00 00 -> done=1 two cycles after the second byte. mem_valid never asserted. words_written=0.
- Header 01 01 (257), MAX_WORDS=256 -> error=1. No write issued. cpu_rst_n stays 0. in_ready=0.
- Responder delays mem_ready 5 cycles -> mem_addr/wdata/wstrb unchanged throughout. Exactly one completion. No duplicate words_written increment from the stale ready in GAP.
- mem_ready tied 0, TIMEOUT_CYCLES=16 -> mem_valid drops and error=1 after 16 WRITE cycles. done=0.
- rst_n pulsed low after 2 payload bytes -> all outputs at reset values asynchronously. Re-sent header 01 00 plus 4 bytes -> single write to BASE+0, done=1.
